// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the pipelined MIPS datapath.
// The register file writes on the clock edge and reads combinationally, so
// a value written this cycle is forwarded into the captured operands here.
// This stage also detects load-use hazards, turns them into EX bubbles and
// keeps a saturating count of those bubbles.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              InValid,
    input  logic [REG_W-1:0]  Rs,
    input  logic [REG_W-1:0]  Rt,
    input  logic [REG_W-1:0]  Rd,
    input  logic [DATA_W-1:0] Data1,
    input  logic [DATA_W-1:0] Data2,
    input  logic [DATA_W-1:0] Imm,
    input  logic [7:0]        Ctrl,
    input  logic              WbRegWrite,
    input  logic [REG_W-1:0]  WbWriteReg,
    input  logic [DATA_W-1:0] WbWriteData,
    input  logic              Stall,
    input  logic              Flush,
    output logic              ExValid,
    output logic [REG_W-1:0]  ExRs,
    output logic [REG_W-1:0]  ExRt,
    output logic [REG_W-1:0]  ExRd,
    output logic [DATA_W-1:0] ExA,
    output logic [DATA_W-1:0] ExB,
    output logic [DATA_W-1:0] ExImm,
    output logic [7:0]        ExCtrl,
    output logic              HazardStall,
    output logic [CNT_W-1:0]  BubbleCount
);

    // Bit 6 of the control bundle is MemRead, i.e. the EX instruction is a load.
    localparam int MEMREAD_BIT = 6;

    logic              valid_q, valid_d;
    logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [7:0]        ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] byp_a_s, byp_b_s;
    logic              wb_live_s;
    logic              hazard_s;

    // Write-back forwarding into the operands and load-use hazard detection.
    always_comb begin
        wb_live_s = WbRegWrite && (WbWriteReg != {REG_W{1'b0}});
        if (wb_live_s && (WbWriteReg == Rs)) begin
            byp_a_s = WbWriteData;
        end else begin
            byp_a_s = Data1;
        end
        if (wb_live_s && (WbWriteReg == Rt)) begin
            byp_b_s = WbWriteData;
        end else begin
            byp_b_s = Data2;
        end
        hazard_s = valid_q && ctrl_q[MEMREAD_BIT] && (rt_q != {REG_W{1'b0}}) &&
                   InValid && ((rt_q == Rs) || (rt_q == Rt));
    end

    // Next-state selection: flush, then hold, then bubble-on-hazard, then load.
    always_comb begin
        valid_d = valid_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;
        if (Flush) begin
            valid_d = 1'b0;
            rs_d    = {REG_W{1'b0}};
            rt_d    = {REG_W{1'b0}};
            rd_d    = {REG_W{1'b0}};
            a_d     = {DATA_W{1'b0}};
            b_d     = {DATA_W{1'b0}};
            imm_d   = {DATA_W{1'b0}};
            ctrl_d  = 8'h00;
        end else if (Stall) begin
            valid_d = valid_q;
            ctrl_d  = ctrl_q;
        end else if (hazard_s) begin
            valid_d = 1'b0;
            rs_d    = {REG_W{1'b0}};
            rt_d    = {REG_W{1'b0}};
            rd_d    = {REG_W{1'b0}};
            a_d     = {DATA_W{1'b0}};
            b_d     = {DATA_W{1'b0}};
            imm_d   = {DATA_W{1'b0}};
            ctrl_d  = 8'h00;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            valid_d = InValid;
            rs_d    = Rs;
            rt_d    = Rt;
            rd_d    = Rd;
            a_d     = byp_a_s;
            b_d     = byp_b_s;
            imm_d   = Imm;
            if (InValid) begin
                ctrl_d = Ctrl;
            end else begin
                ctrl_d = 8'h00;
            end
        end
    end

    // Pipeline register; reset discards the in-flight instruction immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            rs_q    <= {REG_W{1'b0}};
            rt_q    <= {REG_W{1'b0}};
            rd_q    <= {REG_W{1'b0}};
            a_q     <= {DATA_W{1'b0}};
            b_q     <= {DATA_W{1'b0}};
            imm_q   <= {DATA_W{1'b0}};
            ctrl_q  <= 8'h00;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ExValid     = valid_q;
    assign ExRs        = rs_q;
    assign ExRt        = rt_q;
    assign ExRd        = rd_q;
    assign ExA         = a_q;
    assign ExB         = b_q;
    assign ExImm       = imm_q;
    assign ExCtrl      = ctrl_q;
    assign HazardStall = hazard_s;
    assign BubbleCount = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage. A second instance with a 4-bit bubble
// counter shares all inputs so counter saturation is reachable quickly.
module tb_id_ex_stage;

    logic        clock;
    logic        reset_n;
    logic        InValid;
    logic [4:0]  Rs, Rt, Rd;
    logic [31:0] Data1, Data2, Imm;
    logic [7:0]  Ctrl;
    logic        WbRegWrite;
    logic [4:0]  WbWriteReg;
    logic [31:0] WbWriteData;
    logic        Stall, Flush;

    logic        ExValid;
    logic [4:0]  ExRs, ExRt, ExRd;
    logic [31:0] ExA, ExB, ExImm;
    logic [7:0]  ExCtrl;
    logic        HazardStall;
    logic [15:0] BubbleCount;

    logic        s_ExValid;
    logic [4:0]  s_ExRs, s_ExRt, s_ExRd;
    logic [31:0] s_ExA, s_ExB, s_ExImm;
    logic [7:0]  s_ExCtrl;
    logic        s_HazardStall;
    logic [3:0]  s_BubbleCount;

    int n_checks = 0;
    int n_errors = 0;

    id_ex_stage dut (
        .clock(clock), .reset_n(reset_n), .InValid(InValid),
        .Rs(Rs), .Rt(Rt), .Rd(Rd), .Data1(Data1), .Data2(Data2), .Imm(Imm),
        .Ctrl(Ctrl), .WbRegWrite(WbRegWrite), .WbWriteReg(WbWriteReg),
        .WbWriteData(WbWriteData), .Stall(Stall), .Flush(Flush),
        .ExValid(ExValid), .ExRs(ExRs), .ExRt(ExRt), .ExRd(ExRd),
        .ExA(ExA), .ExB(ExB), .ExImm(ExImm), .ExCtrl(ExCtrl),
        .HazardStall(HazardStall), .BubbleCount(BubbleCount)
    );

    id_ex_stage #(.CNT_W(4)) dut_small (
        .clock(clock), .reset_n(reset_n), .InValid(InValid),
        .Rs(Rs), .Rt(Rt), .Rd(Rd), .Data1(Data1), .Data2(Data2), .Imm(Imm),
        .Ctrl(Ctrl), .WbRegWrite(WbRegWrite), .WbWriteReg(WbWriteReg),
        .WbWriteData(WbWriteData), .Stall(Stall), .Flush(Flush),
        .ExValid(s_ExValid), .ExRs(s_ExRs), .ExRt(s_ExRt), .ExRd(s_ExRd),
        .ExA(s_ExA), .ExB(s_ExB), .ExImm(s_ExImm), .ExCtrl(s_ExCtrl),
        .HazardStall(s_HazardStall), .BubbleCount(s_BubbleCount)
    );

    // Free-running clock, 10 time-unit period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] imm,
                             input logic [7:0] ctrl);
        InValid = v; Rs = rs; Rt = rt; Rd = rd;
        Data1 = d1; Data2 = d2; Imm = imm; Ctrl = ctrl;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] reg_i, input logic [31:0] data);
        WbRegWrite = we; WbWriteReg = reg_i; WbWriteData = data;
    endtask

    initial begin
        reset_n = 1'b0; Stall = 1'b0; Flush = 1'b0;
        set_instr(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 8'h00);
        set_wb(1'b0, 5'd0, 32'h0);
        #12;
        check_eq("reset_valid", {31'd0, ExValid}, 32'd0);
        check_eq("reset_cnt", {16'd0, BubbleCount}, 32'd0);
        reset_n = 1'b1;
        step();

        // Plain capture, no write-back
        set_instr(1'b1, 5'd3, 5'd4, 5'd9, 32'h11111111, 32'h22222222, 32'hFFFFFFF0, 8'h8A);
        step();
        check_eq("pass_A", ExA, 32'h11111111);
        check_eq("pass_B", ExB, 32'h22222222);
        check_eq("pass_ctrl", {24'd0, ExCtrl}, 32'h8A);
        check_eq("pass_valid", {31'd0, ExValid}, 32'd1);
        check_eq("pass_rs", {27'd0, ExRs}, 32'd3);
        check_eq("pass_rt", {27'd0, ExRt}, 32'd4);
        check_eq("pass_rd", {27'd0, ExRd}, 32'd9);
        check_eq("pass_imm", ExImm, 32'hFFFFFFF0);

        // Invalid decode slot gives zeroed control
        set_instr(1'b0, 5'd3, 5'd4, 5'd9, 32'h1, 32'h2, 32'h3, 8'h8A);
        step();
        check_eq("inv_valid", {31'd0, ExValid}, 32'd0);
        check_eq("inv_ctrl", {24'd0, ExCtrl}, 32'h00);

        // Write-back bypass on both operands
        set_instr(1'b1, 5'd7, 5'd7, 5'd1, 32'hAAAA0000, 32'hAAAA0000, 32'h0, 8'h8A);
        set_wb(1'b1, 5'd7, 32'hDEADBEEF);
        step();
        check_eq("byp_A", ExA, 32'hDEADBEEF);
        check_eq("byp_B", ExB, 32'hDEADBEEF);

        // Bypass on Rs only
        set_instr(1'b1, 5'd7, 5'd8, 5'd1, 32'hAAAA0000, 32'h12345678, 32'h0, 8'h8A);
        step();
        check_eq("bypRs_A", ExA, 32'hDEADBEEF);
        check_eq("bypRs_B", ExB, 32'h12345678);

        // Write-back enable low: no bypass
        set_instr(1'b1, 5'd7, 5'd7, 5'd1, 32'hAAAA0000, 32'hAAAA0000, 32'h0, 8'h8A);
        set_wb(1'b0, 5'd7, 32'hDEADBEEF);
        step();
        check_eq("nowe_A", ExA, 32'hAAAA0000);

        // Register 0 never bypassed
        set_instr(1'b1, 5'd0, 5'd0, 5'd1, 32'hAAAA0000, 32'hAAAA0000, 32'h0, 8'h8A);
        set_wb(1'b1, 5'd0, 32'hDEADBEEF);
        step();
        check_eq("r0_A", ExA, 32'hAAAA0000);
        check_eq("r0_B", ExB, 32'hAAAA0000);
        set_wb(1'b0, 5'd0, 32'h0);

        // Load-use hazard on Rs
        set_instr(1'b1, 5'd1, 5'd5, 5'd0, 32'h0, 32'h0, 32'h4, 8'hD8);
        step();
        set_instr(1'b1, 5'd5, 5'd6, 5'd2, 32'h55, 32'h66, 32'h0, 8'h8A);
        #1;
        check_eq("lu_hazard", {31'd0, HazardStall}, 32'd1);
        step();
        check_eq("lu_valid", {31'd0, ExValid}, 32'd0);
        check_eq("lu_ctrl", {24'd0, ExCtrl}, 32'h00);
        check_eq("lu_cnt", {16'd0, BubbleCount}, 32'd1);
        check_eq("lu_hz_clear", {31'd0, HazardStall}, 32'd0);
        step();
        check_eq("lu_reload_valid", {31'd0, ExValid}, 32'd1);
        check_eq("lu_reload_ctrl", {24'd0, ExCtrl}, 32'h8A);
        check_eq("lu_reload_A", ExA, 32'h55);

        // Load-use via Rt; and a load targeting r0 never hazards
        set_instr(1'b1, 5'd1, 5'd9, 5'd0, 32'h0, 32'h0, 32'h0, 8'hD8);
        step();
        set_instr(1'b1, 5'd2, 5'd9, 5'd3, 32'h0, 32'h0, 32'h0, 8'h8A);
        #1;
        check_eq("lu_rt_hazard", {31'd0, HazardStall}, 32'd1);
        InValid = 1'b0;
        #1;
        check_eq("lu_inv_nohaz", {31'd0, HazardStall}, 32'd0);
        set_instr(1'b1, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 8'hD8);
        step();
        set_instr(1'b1, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0, 8'h8A);
        #1;
        check_eq("lu_r0_nohaz", {31'd0, HazardStall}, 32'd0);
        step();

        // Stall holds everything for 3 cycles
        set_instr(1'b1, 5'd10, 5'd11, 5'd12, 32'h1010, 32'h2020, 32'h30, 8'h8A);
        step();
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_instr(1'b1, 5'(13 + i), 5'(20 + i), 5'd1, 32'h5000 + i, 32'h6000 + i, 32'h7, 8'h03);
            step();
            check_eq("stall_A", ExA, 32'h1010);
            check_eq("stall_rs", {27'd0, ExRs}, 32'd10);
            check_eq("stall_ctrl", {24'd0, ExCtrl}, 32'h8A);
        end
        Stall = 1'b0;

        // Stall beats the hazard: no bubble counted
        set_instr(1'b1, 5'd1, 5'd5, 5'd0, 32'h0, 32'h0, 32'h0, 8'hD8);
        step();
        Stall = 1'b1;
        set_instr(1'b1, 5'd5, 5'd6, 5'd2, 32'h0, 32'h0, 32'h0, 8'h8A);
        step();
        check_eq("stallhz_cnt", {16'd0, BubbleCount}, 32'd1);
        check_eq("stallhz_ctrl", {24'd0, ExCtrl}, 32'hD8);

        // Flush beats Stall and the hazard
        Flush = 1'b1;
        step();
        check_eq("flush_valid", {31'd0, ExValid}, 32'd0);
        check_eq("flush_ctrl", {24'd0, ExCtrl}, 32'h00);
        check_eq("flush_rt", {27'd0, ExRt}, 32'd0);
        check_eq("flush_cnt", {16'd0, BubbleCount}, 32'd1);
        Flush = 1'b0; Stall = 1'b0;

        // Asynchronous reset mid-run
        set_instr(1'b1, 5'd3, 5'd4, 5'd5, 32'h99, 32'h88, 32'h77, 8'h8A);
        step();
        check_eq("pre_rst_valid", {31'd0, ExValid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("arst_valid", {31'd0, ExValid}, 32'd0);
        check_eq("arst_A", ExA, 32'd0);
        check_eq("arst_imm", ExImm, 32'd0);
        check_eq("arst_ctrl", {24'd0, ExCtrl}, 32'd0);
        check_eq("arst_cnt", {16'd0, BubbleCount}, 32'd0);
        step();
        reset_n = 1'b1;
        InValid = 1'b0;
        step();
        check_eq("post_rst_cnt", {16'd0, BubbleCount}, 32'd0);
        check_eq("post_rst_hz", {31'd0, HazardStall}, 32'd0);

        // 2^4+3 load-use events: wide counter reaches 19, narrow one sticks at 0xF
        for (int i = 0; i < 19; i++) begin
            set_instr(1'b1, 5'd1, 5'd5, 5'd0, 32'h0, 32'h0, 32'h0, 8'hD8);
            step();
            set_instr(1'b1, 5'd5, 5'd6, 5'd2, 32'h0, 32'h0, 32'h0, 8'h8A);
            step();
        end
        check_eq("sat_wide_cnt", {16'd0, BubbleCount}, 32'd19);
        check_eq("sat_narrow_cnt", {28'd0, s_BubbleCount}, 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
